// File: rtl/dm_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dm_bus_arbiter_pkg
//
// Shared definitions for the data-memory / timer bus arbiter:
//   - default address windows for DM, TC1 and TC2
//   - timer register window size and count-register word offset
//   - slave-select encoding carried from decode into the response pipeline
//   - window hit helper used by the address decoder
// ---------------------------------------------------------------------------
package dm_bus_arbiter_pkg;

    // Default address map. DM always starts at byte address 0.
    localparam logic [31:0] DM_END_DEFAULT   = 32'h0000_2fff;
    localparam logic [31:0] TC1_BASE_DEFAULT = 32'h0000_7f00;
    localparam logic [31:0] TC2_BASE_DEFAULT = 32'h0000_7f10;

    // Each timer exposes three 32-bit registers (12 bytes).
    localparam logic [31:0] TC_WINDOW_BYTES = 32'd12;

    // Word offset of the read-only count register (byte offset 8).
    localparam logic [1:0]  TC_COUNT_WORD   = 2'd2;

    // Which slave a granted access targets.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_DM   = 2'd1,
        SEL_TC1  = 2'd2,
        SEL_TC2  = 2'd3
    } slave_sel_t;

    // True when addr falls inside the timer window starting at base.
    function automatic logic tc_window_hit(input logic [31:0] addr,
                                           input logic [31:0] base);
        return (addr >= base) && (addr <= (base + TC_WINDOW_BYTES - 32'd1));
    endfunction

endpackage

// File: rtl/dm_bus_arbiter_addr_decode.sv
// ---------------------------------------------------------------------------
// dm_addr_decode
//
// Combinational decode of the winning master's access into a slave select
// and an error flag. An erroring access always reports SEL_NONE so that no
// slave strobe can be raised for it.
//
// Ports:
//   addr  in  32  byte address of the granted access
//   be    in  4   byte enables
//   we    in  1   1 = write
//   sel   out 2   slave_sel_t encoding (SEL_NONE on error)
//   err   out 1   access rejected
// ---------------------------------------------------------------------------
module dm_addr_decode
    import dm_bus_arbiter_pkg::*;
#(
    parameter logic [31:0] DM_END   = DM_END_DEFAULT,
    parameter logic [31:0] TC1_BASE = TC1_BASE_DEFAULT,
    parameter logic [31:0] TC2_BASE = TC2_BASE_DEFAULT
) (
    input  logic [31:0] addr,
    input  logic [3:0]  be,
    input  logic        we,
    output logic [1:0]  sel,
    output logic        err
);

    logic hit_dm;
    logic hit_tc1;
    logic hit_tc2;
    logic hit_tc;
    logic bad_be;
    logic bad_count_wr;

    // Timer bases are 16-byte aligned, so addr[3:2] is the register word
    // offset inside either timer window.
    always_comb begin
        hit_dm       = (addr <= DM_END);
        hit_tc1      = tc_window_hit(addr, TC1_BASE);
        hit_tc2      = tc_window_hit(addr, TC2_BASE);
        hit_tc       = hit_tc1 || hit_tc2;
        bad_be       = (be == 4'h0) || (hit_tc && (be != 4'hF));
        bad_count_wr = hit_tc && we && (addr[3:2] == TC_COUNT_WORD);

        err = bad_be || bad_count_wr || !(hit_dm || hit_tc);

        if (err) begin
            sel = SEL_NONE;
        end else if (hit_dm) begin
            sel = SEL_DM;
        end else if (hit_tc1) begin
            sel = SEL_TC1;
        end else begin
            sel = SEL_TC2;
        end
    end

endmodule

// File: rtl/dm_bus_arbiter.sv
// ---------------------------------------------------------------------------
// dm_bus_arbiter
//
// Shares the single-port data memory and the two timer register banks
// between the CPU M-stage (M0) and the DMA / program loader (M1).
// One access is granted per cycle; its response (read data or write ack,
// possibly flagged as an error) is returned to the winner one cycle later.
// M0 normally wins contention, but M1 is force-granted once it has been
// refused MAX_WAIT times.
//
// Ports:
//   clk                    in   1   clock, rising edge
//   reset                  in   1   asynchronous reset, active low
//   m0_/m1_req,we          in   1   request valid / write
//   m0_/m1_addr            in   32  byte address
//   m0_/m1_be              in   4   byte enables
//   m0_/m1_wdata           in   32  write data
//   m0_/m1_gnt             out  1   request accepted this cycle
//   m0_/m1_rvalid          out  1   response valid (cycle after gnt)
//   m0_/m1_rdata           out  32  read data, 0 on write or error
//   m0_/m1_err             out  1   response is an error
//   dm_en, dm_we           out  1   DM strobe / write
//   dm_addr, dm_be         out  32/4 DM address / byte enables
//   dm_wdata               out  32  DM write data
//   dm_rdata               in   32  DM read data (cycle after dm_en)
//   tc1_en/we, tc2_en/we   out  1   timer strobes
//   tc_addr                out  2   timer register word offset
//   tc_wdata               out  32  timer write data
//   tc1_rdata, tc2_rdata   in   32  timer read data (cycle after en)
// ---------------------------------------------------------------------------
module dm_bus_arbiter
    import dm_bus_arbiter_pkg::*;
#(
    parameter int          MAX_WAIT = 4,
    parameter logic [31:0] DM_END   = DM_END_DEFAULT,
    parameter logic [31:0] TC1_BASE = TC1_BASE_DEFAULT,
    parameter logic [31:0] TC2_BASE = TC2_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,

    output logic        dm_en,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,

    output logic        tc1_en,
    output logic        tc1_we,
    output logic        tc2_en,
    output logic        tc2_we,
    output logic [1:0]  tc_addr,
    output logic [31:0] tc_wdata,
    input  logic [31:0] tc1_rdata,
    input  logic [31:0] tc2_rdata
);

    localparam int             CNT_W      = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt;

    logic        m1_wins;
    logic        any_gnt;
    logic        win_we;
    logic [31:0] win_addr;
    logic [3:0]  win_be;
    logic [31:0] win_wdata;

    logic [1:0]  dec_sel_raw;
    slave_sel_t  dec_sel;
    logic        dec_err;
    logic        legal;

    logic        rsp_valid;
    logic        rsp_owner;
    slave_sel_t  rsp_sel;
    logic        rsp_we;
    logic        rsp_err;
    logic [31:0] rsp_data;

    // Arbitration. 'reset' is active low, so every grant is suppressed
    // while it is held at 0. M1 takes the bus when alone or when it has
    // been starved for MAX_WAIT cycles.
    always_comb begin
        m1_wins   = reset && m1_req && (!m0_req || (wait_cnt == WAIT_LIMIT));
        m1_gnt    = m1_wins;
        m0_gnt    = reset && m0_req && !m1_wins;
        any_gnt   = m0_gnt || m1_gnt;

        win_we    = m1_wins ? m1_we    : m0_we;
        win_addr  = m1_wins ? m1_addr  : m0_addr;
        win_be    = m1_wins ? m1_be    : m0_be;
        win_wdata = m1_wins ? m1_wdata : m0_wdata;
    end

    dm_addr_decode #(
        .DM_END   (DM_END),
        .TC1_BASE (TC1_BASE),
        .TC2_BASE (TC2_BASE)
    ) u_decode (
        .addr (win_addr),
        .be   (win_be),
        .we   (win_we),
        .sel  (dec_sel_raw),
        .err  (dec_err)
    );

    assign dec_sel = slave_sel_t'(dec_sel_raw);
    assign legal   = any_gnt && !dec_err;

    // Slave strobes only fire for a legal granted access; address, byte
    // enables and data are passed straight through from the winner.
    always_comb begin
        dm_en    = legal && (dec_sel == SEL_DM);
        dm_we    = dm_en && win_we;
        tc1_en   = legal && (dec_sel == SEL_TC1);
        tc1_we   = tc1_en && win_we;
        tc2_en   = legal && (dec_sel == SEL_TC2);
        tc2_we   = tc2_en && win_we;

        dm_addr  = win_addr;
        dm_be    = win_be;
        dm_wdata = win_wdata;
        tc_addr  = win_addr[3:2];
        tc_wdata = win_wdata;
    end

    // Starvation counter for M1: counts refused cycles (saturating) and
    // clears the moment M1 is granted, including on a forced grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (m1_gnt) begin
            wait_cnt <= '0;
        end else if (m1_req && (wait_cnt != WAIT_LIMIT)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Response pipeline stage: remembers who was granted and what kind of
    // access it was, so the slave read data arriving next cycle can be
    // steered to the right master. Reset drops any pending response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_owner <= 1'b0;
            rsp_sel   <= SEL_NONE;
            rsp_we    <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= any_gnt;
            rsp_owner <= m1_gnt;
            rsp_sel   <= dec_sel;
            rsp_we    <= win_we;
            rsp_err   <= dec_err;
        end
    end

    // Read data is only forwarded for a legal read; writes and errors
    // return zero.
    always_comb begin
        rsp_data = 32'h0;
        if (rsp_valid && !rsp_err && !rsp_we) begin
            case (rsp_sel)
                SEL_DM:  rsp_data = dm_rdata;
                SEL_TC1: rsp_data = tc1_rdata;
                SEL_TC2: rsp_data = tc2_rdata;
                default: rsp_data = 32'h0;
            endcase
        end
    end

    always_comb begin
        m0_rvalid = rsp_valid && !rsp_owner;
        m0_err    = m0_rvalid && rsp_err;
        m0_rdata  = m0_rvalid ? rsp_data : 32'h0;

        m1_rvalid = rsp_valid && rsp_owner;
        m1_err    = m1_rvalid && rsp_err;
        m1_rdata  = m1_rvalid ? rsp_data : 32'h0;
    end

endmodule
